// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// stream_mux_rr_if : N-channel input streams plus one registered output stream
// Rev 1.0
// ============================================================================
interface stream_mux_rr_if #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
);
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : N:1 valid/ready stream mux, fixed-select or round-robin,
//                 with a single registered output stage
// Rev 1.0
// ============================================================================
module stream_mux_rr #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = $clog2(N),
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  stream_mux_rr_if.slave  bus
);

  logic [SELW-1:0] r_rr_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_chan;

  logic            w_gvalid;
  logic [SELW-1:0] w_gidx;
  logic [N-1:0]    w_grant;
  logic [W-1:0]    w_sel_data;
  logic            w_load_en;
  logic            w_fire;
  logic [SELW-1:0] w_ptr_next;

  generate
    if (MODE == 0) begin : g_fixed_sel
      // An out-of-range sel matches no channel, so it simply yields no grant.
      always_comb begin
        w_gvalid = 1'b0;
        w_gidx   = bus.sel;
        for (int i = 0; i < N; i++) begin
          if (bus.sel == SELW'(i)) begin
            w_gvalid = bus.in_valid[i];
          end
        end
      end
    end else begin : g_round_robin
      always_comb begin
        int c;
        w_gvalid = 1'b0;
        w_gidx   = '0;
        c        = 0;
        for (int k = 0; k < N; k++) begin
          c = int'(r_rr_ptr) + k;
          if (c >= N) begin
            c = c - N;
          end
          if (!w_gvalid && bus.in_valid[c]) begin
            w_gvalid = 1'b1;
            w_gidx   = SELW'(c);
          end
        end
      end
    end
  endgenerate

  assign w_load_en = !r_out_valid || bus.out_ready;
  assign w_fire    = w_gvalid && w_load_en && !reset;

  always_comb begin
    w_grant    = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gidx == SELW'(i)) begin
        w_grant[i] = w_gvalid;
        w_sel_data = bus.in_data[i*W +: W];
      end
    end
  end

  // Explicit wrap keeps non-power-of-two N correct.
  assign w_ptr_next = (w_gidx == SELW'(N-1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_chan  <= w_gidx;
      r_rr_ptr    <= w_ptr_next;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_grant & {N{w_load_en && !reset}};
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// tb_stream_mux_rr : four configurations (N=4/3, fixed/round-robin) driven by
//                    shared stimulus and checked against a behavioural model
// Rev 1.0
// ============================================================================
module tb_stream_mux_rr;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   stim_valid = '0;
  logic [127:0] stim_data = '0;
  logic [1:0]   stim_sel = '0;
  logic         stim_ordy = 1'b0;

  logic [3:0][3:0]  obs_ready;
  logic [3:0][31:0] obs_data;
  logic [3:0][1:0]  obs_chan;
  logic [3:0]       obs_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // instance k: N and MODE
  int ni[4] = '{4, 4, 3, 3};
  int mi[4] = '{0, 1, 0, 1};

  // reference model state (word stage contents and arbitration pointer)
  bit          m_valid[4];
  logic [31:0] m_data[4];
  int          m_chan[4];
  int          m_ptr[4];

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_dut
      localparam int NK = (k < 2) ? 4 : 3;
      localparam int MK = k % 2;
      stream_mux_rr_if #(.W(32), .N(NK)) bus ();
      assign bus.in_data   = stim_data[NK*32-1:0];
      assign bus.in_valid  = stim_valid[NK-1:0];
      assign bus.sel       = stim_sel;
      assign bus.out_ready = stim_ordy;
      stream_mux_rr #(.W(32), .N(NK), .MODE(MK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
      assign obs_ready[k] = 4'(bus.in_ready);
      assign obs_data[k]  = bus.out_data;
      assign obs_chan[k]  = bus.out_chan;
      assign obs_valid[k] = bus.out_valid;
    end
  endgenerate

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [127:0] d,
                      input logic [1:0] s, input logic ordy);
    bit          nv[4];
    logic [31:0] nd[4];
    int          nc[4];
    int          np[4];
    @(negedge clk);
    reset      = r;
    stim_valid = v;
    stim_data  = d;
    stim_sel   = s;
    stim_ordy  = ordy;
    #1;
    for (int k = 0; k < 4; k++) begin
      int   n    = ni[k];
      bit   le   = !m_valid[k] || ordy;
      bit   have = 0;
      int   g    = 0;
      logic [3:0] exp_rdy;
      if (mi[k] == 0) begin
        if (int'(s) < n && v[s]) begin
          have = 1;
          g    = int'(s);
        end
      end else begin
        for (int off = 0; off < n; off++) begin
          int c = (m_ptr[k] + off) % n;
          if (!have && v[c]) begin
            have = 1;
            g    = c;
          end
        end
      end
      exp_rdy = (have && le && !r) ? 4'(1 << g) : 4'd0;
      check_val($sformatf("in_ready[%0d]", k), 64'(obs_ready[k]), 64'(exp_rdy));
      nv[k] = m_valid[k]; nd[k] = m_data[k]; nc[k] = m_chan[k]; np[k] = m_ptr[k];
      if (r) begin
        nv[k] = 0; nd[k] = '0; nc[k] = 0; np[k] = 0;
      end else if (have && le) begin
        nv[k] = 1; nd[k] = d[g*32 +: 32]; nc[k] = g; np[k] = (g + 1) % n;
      end else if (ordy) begin
        nv[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = nv[k]; m_data[k] = nd[k]; m_chan[k] = nc[k]; m_ptr[k] = np[k];
      check_val($sformatf("out_valid[%0d]", k), 64'(obs_valid[k]), 64'(m_valid[k]));
      check_val($sformatf("out_data[%0d]", k),  64'(obs_data[k]),  64'(m_data[k]));
      check_val($sformatf("out_chan[%0d]", k),  64'(obs_chan[k]),  64'(m_chan[k]));
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] sweep;
    int exp4[6];
    int exp3[4];
    int alt[4];
    sweep = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    exp4  = '{0, 1, 2, 3, 0, 1};
    exp3  = '{0, 1, 2, 0};
    alt   = '{1, 3, 1, 3};
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 0; m_data[k] = '0; m_chan[k] = 0; m_ptr[k] = 0;
    end

    // reset with all channels valid, then the first word one cycle later
    step(1, 4'b1111, sweep, 2'd0, 1);
    step(1, 4'b1111, sweep, 2'd0, 1);
    check_val("reset_out_valid", 64'(obs_valid[0]), 64'd0);
    check_val("reset_out_data", 64'(obs_data[0]), 64'd0);

    // fixed-select sweep
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b1111, sweep, 2'(i), 1);
      check_val($sformatf("sweep_chan%0d", i), 64'(obs_chan[0]), 64'(i));
      check_val($sformatf("sweep_data%0d", i), 64'(obs_data[0]), 64'(sweep[i*32 +: 32]));
    end

    // selected channel not valid; sel=3 is out of range for N=3
    step(0, 4'b1011, sweep, 2'd2, 1);
    check_val("nogrant_drain", 64'(obs_valid[0]), 64'd0);
    step(0, 4'b1111, sweep, 2'd3, 1);
    check_val("oob_sel_n3", 64'(obs_valid[2]), 64'd0);

    // backpressure holds the word and blocks every input
    step(0, 4'b1111, {96'h0, 32'h1234_5678}, 2'd0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'($urandom), rnd128(), 2'($urandom), 0);
      check_val("bp_hold", 64'(obs_data[0]), 64'h1234_5678);
    end
    step(0, 4'b1111, sweep, 2'd1, 1);
    check_val("bp_reload", 64'(obs_data[0]), 64'hBBBB_0001);

    // round-robin fairness from a fresh pointer
    step(1, 4'b0000, sweep, 2'd0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 4'b1111, sweep, 2'd0, 1);
      check_val($sformatf("rr4_seq%0d", i), 64'(obs_chan[1]), 64'(exp4[i]));
      if (i < 4) check_val($sformatf("rr3_seq%0d", i), 64'(obs_chan[3]), 64'(exp3[i]));
    end
    step(1, 4'b0000, sweep, 2'd0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b1010, sweep, 2'd0, 1);
      check_val($sformatf("rr_alt%0d", i), 64'(obs_chan[1]), 64'(alt[i]));
    end

    // reset mid-stream loses the held word and restarts arbitration at 0
    step(1, 4'b0000, sweep, 2'd0, 1);
    step(0, 4'b1111, sweep, 2'd0, 1);
    step(0, 4'b1111, sweep, 2'd0, 0);
    step(1, 4'b1111, sweep, 2'd0, 0);
    check_val("midrst_valid", 64'(obs_valid[1]), 64'd0);
    step(0, 4'b1111, sweep, 2'd0, 1);
    check_val("midrst_first", 64'(obs_chan[1]), 64'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom), rnd128(), 2'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel successor to the 4:1 word select mux.
- Selects one of N valid/ready input streams and registers the chosen word into a single output stage.
- Selection is either externally steered (fixed-select mode) or round-robin arbitrated.
- Sits between multiple producers (e.g. ALU result, memory read data, PC+4, immediate path) and a single downstream consumer such as the register-file write port or a pipeline register.

Parameters:
- W, 32, data word width in bits.
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), width of the select and channel-tag fields.
- MODE, 0: 0 = external select via sel; 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i holds a word.
- in_ready  output  N  channel i word accepted this cycle when in_valid[i] && in_ready[i].
- sel  input  SELW  channel to forward (MODE 0 only).
- out_data  output  W  registered selected word.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (sync, active-high), values on the next edge: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0. Any held word is dropped. The reset cycle accepts no input.
- load_en = !out_valid || out_ready: the output stage is empty or draining this cycle.
- Grant is combinational and one-hot; at most one in_ready bit is high.
- in_ready[i] = grant[i] && load_en && !reset. A handshake on channel i loads in_data[i] and i into out_data/out_chan and sets out_valid = 1 at the next edge.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle when out_ready stays high.
- If out_valid && out_ready and there is no grant, out_valid clears at the next edge. out_data and out_chan keep their last values.
- Hold rule: while out_valid && !out_ready, out_data and out_chan remain stable and all in_ready bits are 0.
- MODE 0 grant:
  - grant[sel] = in_valid[sel].
  - If sel >= N (out of range when N is not a power of 2), there is no grant.
  - sel is sampled only in the cycle the handshake occurs.
- MODE 1 grant:
  - Search from rr_ptr upward, wrapping N-1 -> 0. Grant the first i with in_valid[i].
  - On a handshake with channel g: rr_ptr <= (g+1) mod N.
  - Without a handshake, rr_ptr holds.
  - Starvation-free: any asserted valid is served within N handshakes.
- Simultaneous drain and load (out_valid && out_ready && grant): the old word leaves and the new word loads at the same edge. out_valid stays 1.
- Arithmetic: the rr_ptr increment wraps modulo N, so N that is not a power of 2 is handled explicitly.
- in_data on non-granted channels has no effect.
- Structure: fully synchronous, single clock domain.
- No latches: every combinational path assigns a default value (unlike a priority if-chain with no final else).

Test Plan:
- Reset then idle (N=4, W=32): assert reset for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0 during reset; first word appears 1 cycle after reset deasserts.
- MODE 0 select sweep: out_ready=1, in_valid=4'b1111, in_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, sel=0,1,2,3 on consecutive cycles -> out_data = AAAA_0000, BBBB_0001, CCCC_0002, DDDD_0003 with out_chan 0..3, each one cycle after its sel value.
- MODE 0 invalid selection: sel=2, in_valid=4'b1011 -> in_ready=0 and out_valid drops after the current word drains.
  - Same check with N=3 and sel=3: no grant.
- Backpressure: out_valid=1 with word 32'h1234_5678, out_ready=0 for 5 cycles while inputs change -> out_data stays 1234_5678 and in_ready=0 throughout.
  - Then out_ready=1 -> the next granted word loads at the same edge the old one drains.
- MODE 1 fairness: in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0,1.
  - With in_valid=4'b1010 -> sequence 1,3,1,3.
  - With N=3 -> wrap 0,1,2,0.
- Reset mid-stream (MODE 1): after grants 0,1 (rr_ptr=2) with out_valid=1, assert reset for 1 cycle -> out_valid=0, the held word is lost, and the first post-reset grant goes to channel 0.
